// File: rtl/shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational shift of up to STEP bits, built as binary-weighted stages
// (1, 2, 4, ... bits), each applying the selected operation when enabled.
module shift_step_unit
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int S_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] work,
  input  op_e              op,
  input  logic [S_W-1:0]   s,
  output logic [WIDTH-1:0] shifted
);

  function automatic logic [WIDTH-1:0] apply(input logic [WIDTH-1:0] x, input op_e o,
                                             input int amt);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = x << amt;
      OP_SRL:  r = x >> amt;
      OP_SRA:  r = WIDTH'($signed(x) >>> amt);
      default: r = (x >> amt) | (x << (WIDTH - amt));
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] stage [S_W+1];

  assign stage[0] = work;

  for (genvar i = 0; i < S_W; i++) begin : g_stage
    localparam int AMT = 1 << i;
    assign stage[i+1] = s[i] ? apply(stage[i], op, AMT) : stage[i];
  end

  assign shifted = stage[S_W];

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit that consumes up to STEP bits of the shift
// amount per clock, with a start/ready/valid handshake.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         ctrl_op,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic [WIDTH-1:0]   data_operandA,
  output logic               ready,
  output logic               busy,
  output logic               result_valid,
  output logic [WIDTH-1:0]   data_result
);

  localparam int S_W = $clog2(STEP + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_src;
  logic [WIDTH-1:0]   work_q, work_d, work_src, shifted;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, cnt_src, cnt_rem;
  logic [S_W-1:0]     s;
  logic               accept;

  assign accept = start && (state_q != ST_SHIFT);

  // The accept edge already performs the first step, so an operation needs
  // max(1, ceil(shamt/STEP)) edges from accept to result_valid.
  always_comb begin
    if (state_q == ST_SHIFT) begin
      work_src = work_q;
      op_src   = op_q;
      cnt_src  = cnt_q;
    end else begin
      work_src = data_operandA;
      op_src   = op_e'(ctrl_op);
      cnt_src  = ctrl_shiftamt;
    end
    if (int'(cnt_src) > STEP) s = S_W'(STEP);
    else                      s = S_W'(cnt_src);
    cnt_rem = cnt_src - SHAMT_W'(s);
  end

  shift_step_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .work    (work_src),
    .op      (op_src),
    .s       (s),
    .shifted (shifted)
  );

  // NOTE: every signal is given its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    if ((state_q == ST_SHIFT) || accept) begin
      work_d = shifted;
      cnt_d  = cnt_rem;
      op_d   = op_src;
      if (cnt_rem == '0) begin
        state_d  = ST_DONE;
        result_d = shifted;
      end else begin
        state_d  = ST_SHIFT;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign ready        = (state_q != ST_SHIFT);
  assign busy         = (state_q == ST_SHIFT);
  assign result_valid = (state_q == ST_DONE);
  assign data_result  = result_q;

endmodule
